// File: rtl/jstep_monitor_pkg.sv
// Shared definitions for the stepper monitor: step count, error codes, FSM states.
package jstep_monitor_pkg;

  localparam int unsigned NSTEPS = 6;
  localparam int unsigned STEP_W = 3;
  localparam int unsigned CODE_W = 3;

  localparam logic [CODE_W-1:0] ERR_NONE    = 3'd0;
  localparam logic [CODE_W-1:0] ERR_MULTI   = 3'd1;
  localparam logic [CODE_W-1:0] ERR_SKIP    = 3'd2;
  localparam logic [CODE_W-1:0] ERR_GAP     = 3'd3;
  localparam logic [CODE_W-1:0] ERR_SETNOEN = 3'd4;
  localparam logic [CODE_W-1:0] ERR_SETCNT  = 3'd5;

  typedef enum logic [1:0] {
    SYNC  = 2'd0,
    TRACK = 2'd1,
    ERROR = 2'd2
  } state_t;

  // Successor of a step number, wrapping the last step back to step 1.
  function automatic logic [STEP_W-1:0] next_step(input logic [STEP_W-1:0] s);
    return (s == STEP_W'(NSTEPS)) ? STEP_W'(1) : s + STEP_W'(1);
  endfunction

endpackage

// File: rtl/jonehot6.sv
// Decodes the six step lines: more-than-one-hot flag, all-low flag, 1-based index.
module jonehot6
  import jstep_monitor_pkg::*;
(
  input  logic [0:5]        bos,
  output logic              multi,
  output logic              none,
  output logic [STEP_W-1:0] idx
);

  logic [2:0] cnt;

  // Population count and position of the (last) set line.
  always_comb begin
    cnt = 3'd0;
    idx = '0;
    for (int i = 0; i < 6; i++) begin
      if (bos[i]) begin
        cnt = cnt + 3'd1;
        idx = STEP_W'(i + 1);
      end
    end
  end

  assign multi = (cnt > 3'd1);
  assign none  = (cnt == 3'd0);

endmodule

// File: rtl/jstep_monitor.sv
// Observer of the clock/stepper outputs: tracks the step, counts instructions,
// and latches the first protocol violation.
module jstep_monitor
  import jstep_monitor_pkg::*;
#(
  parameter int unsigned CNT_W   = 16,
  parameter int unsigned MAX_GAP = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wclke,
  input  logic              wclks,
  input  logic [0:5]        bos,
  output logic [STEP_W-1:0] step,
  output logic              synced,
  output logic [CNT_W-1:0]  icount,
  output logic              err,
  output logic [CODE_W-1:0] err_code
);

  localparam int unsigned GAP_W = $clog2(MAX_GAP + 2);

  state_t             state;
  logic [0:5]         bos_q;
  logic               wclke_q;
  logic               wclks_q;
  logic               wclks_qq;
  logic [GAP_W-1:0]   gap_cnt;
  logic [1:0]         set_cnt;
  logic               multi;
  logic               none;
  logic [STEP_W-1:0]  idx;
  logic               rise;
  logic               is_same;
  logic               is_next;
  logic [CODE_W-1:0]  fault;

  // Input sample stage; wclks is delayed once more for edge detection.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bos_q    <= '0;
      wclke_q  <= 1'b0;
      wclks_q  <= 1'b0;
      wclks_qq <= 1'b0;
    end else begin
      bos_q    <= bos;
      wclke_q  <= wclke;
      wclks_q  <= wclks;
      wclks_qq <= wclks_q;
    end
  end

  jonehot6 u_onehot (
    .bos   (bos_q),
    .multi (multi),
    .none  (none),
    .idx   (idx)
  );

  assign rise    = wclks_q & ~wclks_qq;
  assign is_same = !multi && !none && (idx == step);
  assign is_next = !multi && !none && (idx == next_step(step));

  // Violation detect for this sample; later assignments win, so the lowest code is kept.
  always_comb begin
    fault = ERR_NONE;
    if (is_next && set_cnt != 2'd1)        fault = ERR_SETCNT;
    if (wclks_q && !wclke_q)               fault = ERR_SETNOEN;
    if (none && gap_cnt >= GAP_W'(MAX_GAP)) fault = ERR_GAP;
    if (!multi && !none && !is_same && !is_next) fault = ERR_SKIP;
    if (multi)                             fault = ERR_MULTI;
  end

  // Monitor FSM with registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= SYNC;
      step     <= '0;
      synced   <= 1'b0;
      icount   <= '0;
      err      <= 1'b0;
      err_code <= ERR_NONE;
      gap_cnt  <= '0;
      set_cnt  <= '0;
    end else begin
      case (state)
        SYNC: begin
          gap_cnt <= '0;
          set_cnt <= '0;
          if (bos_q == 6'b100000) begin
            step    <= STEP_W'(1);
            synced  <= 1'b1;
            set_cnt <= {1'b0, rise};
            state   <= TRACK;
          end
        end
        TRACK: begin
          if (fault != ERR_NONE) begin
            err      <= 1'b1;
            err_code <= fault;
            synced   <= 1'b0;
            step     <= '0;
            state    <= ERROR;
          end else begin
            if (none && gap_cnt != '1) gap_cnt <= gap_cnt + GAP_W'(1);
            else if (!none)            gap_cnt <= '0;
            if (is_next) begin
              step    <= idx;
              set_cnt <= {1'b0, rise};
              if (step == STEP_W'(NSTEPS)) icount <= icount + CNT_W'(1);
            end else if (rise && set_cnt != 2'd3) begin
              set_cnt <= set_cnt + 2'd1;
            end
          end
        end
        ERROR: ;
        default: state <= SYNC;
      endcase
    end
  end

endmodule

// File: tb/tb_jstep_monitor.sv
// Randomized self-checking bench for jstep_monitor against a behavioural model.
module tb_jstep_monitor;

  localparam int unsigned CNT_W   = 16;
  localparam int unsigned MAX_GAP = 2;

  logic             clk;
  logic             reset;
  logic             wclke;
  logic             wclks;
  logic [0:5]       bos;
  logic [2:0]       step;
  logic             synced;
  logic [CNT_W-1:0] icount;
  logic             err;
  logic [2:0]       err_code;

  jstep_monitor #(.CNT_W(CNT_W), .MAX_GAP(MAX_GAP)) dut (
    .clk      (clk),
    .reset    (reset),
    .wclke    (wclke),
    .wclks    (wclks),
    .bos      (bos),
    .step     (step),
    .synced   (synced),
    .icount   (icount),
    .err      (err),
    .err_code (err_code)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [0:5] b;
    logic       e;
    logic       s;
  } vec_t;

  vec_t pend[$];
  int   n_tests;
  int   n_fail;

  // Reference model: mode 0 waiting for step 1, 1 following, 2 latched error.
  int m_mode, m_step, m_icount, m_code, m_gap, m_pulses;
  bit m_prev_s;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_step = 0; m_icount = 0; m_code = 0;
    m_gap = 0; m_pulses = 0; m_prev_s = 1'b0;
  endtask

  function automatic logic [0:5] onehot(input int k);
    logic [0:5] v;
    v = '0;
    if (k >= 1 && k <= 6) v[k-1] = 1'b1;
    return v;
  endfunction

  function automatic vec_t mk(input logic [0:5] b, input logic e, input logic s);
    vec_t v;
    v.b = b; v.e = e; v.s = s;
    return v;
  endfunction

  task automatic model_apply(input vec_t v);
    int ones, idx, nxt, code;
    bit rise;
    bit [5:0] hit;
    ones = $countones(v.b);
    idx  = 0;
    for (int i = 0; i < 6; i++) if (v.b[i]) idx = i + 1;
    rise = v.s && !m_prev_s;
    m_prev_s = v.s;
    if (m_mode == 0) begin
      if (ones == 1 && idx == 1) begin
        m_mode = 1; m_step = 1; m_gap = 0; m_pulses = rise ? 1 : 0;
      end
    end else if (m_mode == 1) begin
      nxt = (m_step == 6) ? 1 : m_step + 1;
      hit = '0;
      if (ones > 1) hit[1] = 1'b1;
      if (ones == 1 && idx != m_step && idx != nxt) hit[2] = 1'b1;
      if (ones == 0 && m_gap + 1 > MAX_GAP) hit[3] = 1'b1;
      if (v.s && !v.e) hit[4] = 1'b1;
      if (ones == 1 && idx == nxt && m_pulses != 1) hit[5] = 1'b1;
      code = 0;
      for (int c = 5; c >= 1; c--) if (hit[c]) code = c;
      if (code != 0) begin
        m_mode = 2; m_code = code; m_step = 0;
      end else begin
        m_gap = (ones == 0) ? m_gap + 1 : 0;
        if (ones == 1 && idx == nxt) begin
          if (m_step == 6) m_icount = (m_icount + 1) % (1 << CNT_W);
          m_step   = nxt;
          m_pulses = rise ? 1 : 0;
        end else if (rise) begin
          m_pulses = (m_pulses >= 3) ? 3 : m_pulses + 1;
        end
      end
    end
  endtask

  task automatic compare_outputs();
    chk("step",     32'(step),     32'((m_mode == 1) ? m_step : 0));
    chk("synced",   32'(synced),   32'(m_mode == 1));
    chk("icount",   32'(icount),   32'(m_icount));
    chk("err",      32'(err),      32'(m_code != 0));
    chk("err_code", 32'(err_code), 32'(m_code));
  endtask

  // Called at a negedge: outputs now reflect the vector driven two negedges ago.
  task automatic drive_cycle(input vec_t v);
    if (pend.size() == 2) begin
      model_apply(pend.pop_front());
      compare_outputs();
    end
    bos = v.b; wclke = v.e; wclks = v.s;
    pend.push_back(v);
    @(negedge clk);
  endtask

  // Four cycles per step with one set pulse inside enable; optional fault at step fstep.
  // fault: 1 multi-hot, 2 skip, 3 gap before step, 4 set w/o enable, 5 double pulse, 6 no pulse.
  task automatic run_steps(input int start, input int nsteps, input int fault,
                           input int fstep, input int gaplen);
    int cur, nxt;
    bit f;
    logic [0:5] oh;
    for (int s = 0; s < nsteps; s++) begin
      f   = (s == fstep);
      cur = ((start - 1 + s) % 6) + 1;
      if (f && fault == 2) cur = ((cur + 1) % 6) + 1;
      nxt = (cur % 6) + 1;
      if (f && fault == 3) repeat (gaplen) drive_cycle(mk('0, 1'b0, 1'b0));
      oh = onehot(cur);
      drive_cycle(mk(oh, 1'b0, 1'b0));
      drive_cycle(mk(oh, 1'b1, 1'b0));
      drive_cycle(mk((f && fault == 1) ? (oh | onehot(nxt)) : oh,
                     !(f && fault == 4), !(f && fault == 6)));
      drive_cycle(mk(oh, 1'b1, 1'b0));
      if (f && fault == 5) begin
        drive_cycle(mk(oh, 1'b1, 1'b1));
        drive_cycle(mk(oh, 1'b1, 1'b0));
      end
    end
  endtask

  task automatic drain();
    repeat (2) drive_cycle(mk('0, 1'b0, 1'b0));
  endtask

  task automatic apply_reset();
    reset = 1'b0; bos = '0; wclke = 1'b0; wclks = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_step",   32'(step),     32'd0);
    chk("rst_synced", 32'(synced),   32'd0);
    chk("rst_icount", 32'(icount),   32'd0);
    chk("rst_err",    32'(err),      32'd0);
    chk("rst_code",   32'(err_code), 32'd0);
    reset = 1'b1;
    pend.delete();
    model_reset();
  endtask

  // Directed error scenario followed by a check of the latched code.
  task automatic err_case(input string tag, input int start, input int n, input int fault,
                          input int fstep, input int gaplen, input int exp_code);
    apply_reset();
    run_steps(start, n, fault, fstep, gaplen);
    drain();
    chk(tag, 32'(err_code), 32'(exp_code));
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: time %0t beyond limit %0d", $time, 5_000_000);
    $fatal(1);
  end

  initial begin
    int st, n, ft, fs, gl;
    n_tests = 0; n_fail = 0;
    model_reset();

    // Clean run starting mid-instruction: sync at first step 1, three wraps after that.
    apply_reset();
    run_steps(3, 4 + 18 + 2, 0, -1, 0);
    chk("clean_icount", 32'(icount), 32'd3);
    chk("clean_synced", 32'(synced), 32'd1);
    chk("clean_err",    32'(err),    32'd0);

    err_case("code_multi",   1, 4, 1, 1, 0, 1);
    chk("multi_step", 32'(step), 32'd0);
    err_case("code_skip",    1, 4, 2, 2, 0, 2);
    err_case("code_gap3",    1, 4, 3, 2, 3, 3);
    err_case("code_gap2",    1, 4, 3, 2, 2, 0);
    err_case("code_setnoen", 1, 4, 4, 2, 0, 4);
    err_case("code_dblset",  1, 4, 5, 1, 0, 5);
    err_case("code_noset",   1, 4, 6, 1, 0, 5);

    // Asynchronous reset in the middle of step 4 after five instructions.
    apply_reset();
    run_steps(1, 34, 0, -1, 0);
    chk("pre_icount", 32'(icount), 32'd5);
    chk("pre_step",   32'(step),   32'd4);
    #2 reset = 1'b0;
    #1;
    chk("async_step",   32'(step),     32'd0);
    chk("async_synced", 32'(synced),   32'd0);
    chk("async_icount", 32'(icount),   32'd0);
    chk("async_err",    32'(err),      32'd0);
    @(negedge clk);
    reset = 1'b1;
    pend.delete();
    model_reset();
    run_steps(3, 8, 0, -1, 0);
    chk("resync_icount", 32'(icount), 32'd0);
    chk("resync_synced", 32'(synced), 32'd1);

    // Randomized streams with at most one injected fault each.
    for (int k = 0; k < 40; k++) begin
      st = $urandom_range(1, 6);
      n  = $urandom_range(6, 20);
      ft = $urandom_range(0, 6);
      fs = $urandom_range(0, n - 1);
      gl = $urandom_range(1, 3);
      apply_reset();
      run_steps(st, n, ft, fs, gl);
      drain();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
